// File: rtl/internal_ram_port.sv
// rtl/internal_ram_port.sv - valid/ready bus front end for the on-chip RAM macro with ROM write protection
module internal_ram_port #(
    parameter int ADDR_WIDTH = 14,
    parameter int ROM_WORDS  = 1024,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [3:0]            cmd_mask,
    input  logic [31:0]           cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_error,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [11:0]           ram_addr,
    output logic [3:0]            ram_mask,
    output logic [31:0]           ram_wrData,
    input  logic [31:0]           ram_rdData
);

    localparam int            IW      = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] ROM_LIM = IW'(ROM_WORDS);
    localparam logic [1:0]    CREDITS = 2'(RSP_DEPTH);

    logic [IW-1:0] word_idx;
    logic          unused_low_bits;
    logic          is_rom;
    logic          accept;
    logic          pop;
    logic [1:0]    count;

    // one access launched last cycle whose RAM data lands this cycle
    logic          inflight;
    logic          inflight_wr;
    logic          inflight_err;

    // two-entry response buffer
    logic [31:0]   buf_data [2];
    logic          buf_err  [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    buf_count;

    assign word_idx        = cmd_address[ADDR_WIDTH-1:2];
    assign unused_low_bits = ^cmd_address[1:0];
    assign is_rom          = word_idx < ROM_LIM;

    assign count     = buf_count + {1'b0, inflight};
    assign rsp_valid = buf_count != 2'd0;
    assign pop       = rsp_valid && rsp_ready;

    // a slot freed by this cycle's pop may be reused by this cycle's accept
    assign cmd_ready = !reset && ((count < CREDITS) || (count == CREDITS && pop));
    assign accept    = cmd_valid && cmd_ready;

    assign ram_en     = accept;
    assign ram_wr     = accept && cmd_write && !is_rom;
    assign ram_addr   = 12'(word_idx);
    assign ram_mask   = cmd_mask;
    assign ram_wrData = cmd_data;

    assign rsp_data  = rsp_valid ? buf_data[rd_ptr] : 32'd0;
    assign rsp_error = rsp_valid && buf_err[rd_ptr];

    // remember what kind of access went to the RAM so its response can be formed next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight     <= 1'b0;
            inflight_wr  <= 1'b0;
            inflight_err <= 1'b0;
        end else begin
            inflight     <= accept;
            inflight_wr  <= cmd_write;
            inflight_err <= cmd_write && is_rom;
        end
    end

    // buffer pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // response payload storage; writes return zero data
    always_ff @(posedge clk) begin
        if (inflight) begin
            buf_data[wr_ptr] <= inflight_wr ? 32'd0 : ram_rdData;
            buf_err[wr_ptr]  <= inflight_err;
        end
    end

endmodule

// File: tb/tb_internal_ram_port.sv
// tb/tb_internal_ram_port.sv - directed self-checking bench for internal_ram_port
module tb_internal_ram_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [13:0] cmd_address;
    logic [3:0]  cmd_mask;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        ram_en;
    logic        ram_wr;
    logic [11:0] ram_addr;
    logic [3:0]  ram_mask;
    logic [31:0] ram_wrData;
    logic [31:0] ram_rdData;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [4096];
    logic [31:0] rd_q;

    internal_ram_port dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
        .ram_wrData(ram_wrData), .ram_rdData(ram_rdData)
    );

    always #5 clk = ~clk;

    // RAM macro model: byte-masked write, registered read of the old word
    always @(posedge clk) begin
        if (ram_en) begin
            rd_q <= mem[ram_addr];
            if (ram_wr)
                for (int b = 0; b < 4; b++)
                    if (ram_mask[b]) mem[ram_addr][8*b +: 8] <= ram_wrData[8*b +: 8];
        end
    end
    assign ram_rdData = rd_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [13:0] a,
                         input logic [3:0] m, input logic [31:0] d);
        cmd_valid = v; cmd_write = w; cmd_address = a; cmd_mask = m; cmd_data = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 14'h0000, 4'hF, 32'd0);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        step(); step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error); end
        drive(1'b0, 1'b0, 14'h0000, 4'hF, 32'd0);
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 14'h1000, 4'hF, 32'hDEADBEEF);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if ({ram_en, ram_wr, ram_addr} !== {1'b1, 1'b1, 12'h400}) begin bad++; $display("FAIL wr_issue got=%b%b%h exp=11400", ram_en, ram_wr, ram_addr); end
        total++; if (ram_wrData !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data_port got=%h exp=deadbeef", ram_wrData); end
        step();
        drive(1'b1, 1'b0, 14'h1000, 4'h0, 32'd0);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_no_bypass got=%b exp=0", rsp_valid); end
        total++; if ({ram_en, ram_wr} !== 2'b10) begin bad++; $display("FAIL rd_issue got=%b%b exp=10", ram_en, ram_wr); end
        step();
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'd0}) begin bad++; $display("FAIL wr_rsp got=%b%b%h exp=10 00000000", rsp_valid, rsp_error, rsp_data); end
        step();
        total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_rsp got=%b%b%h exp=10 deadbeef", rsp_valid, rsp_error, rsp_data); end
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_masked_write();
        drive(1'b1, 1'b1, 14'h2000, 4'b0101, 32'h11223344);
        total++; if (ram_mask !== 4'b0101) begin bad++; $display("FAIL mask_port got=%b exp=0101", ram_mask); end
        step();
        drive(1'b1, 1'b0, 14'h2000, 4'h0, 32'd0);
        step();
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        step();
        total++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hAA22CC44}) begin bad++; $display("FAIL mask_merge got=%b %h exp=1 aa22cc44", rsp_valid, rsp_data); end
        step();
    endtask

    task automatic test_rom_protect();
        drive(1'b1, 1'b1, 14'h0FFC, 4'hF, 32'h12345678);
        total++; if ({ram_en, ram_wr} !== 2'b10) begin bad++; $display("FAIL rom_issue got=%b%b exp=10", ram_en, ram_wr); end
        step();
        drive(1'b1, 1'b0, 14'h0FFC, 4'hF, 32'd0);
        step();
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b11, 32'd0}) begin bad++; $display("FAIL rom_error got=%b%b%h exp=11 00000000", rsp_valid, rsp_error, rsp_data); end
        step();
        total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'hC0DE03FF}) begin bad++; $display("FAIL rom_unchanged got=%b%b%h exp=10 c0de03ff", rsp_valid, rsp_error, rsp_data); end
        step();
    endtask

    task automatic test_zero_mask();
        drive(1'b1, 1'b1, 14'h3FFC, 4'h0, 32'hFFFFFFFF);
        total++; if ({ram_en, ram_wr} !== 2'b11) begin bad++; $display("FAIL zmask_issue got=%b%b exp=11", ram_en, ram_wr); end
        step();
        drive(1'b1, 1'b0, 14'h3FFC, 4'h0, 32'd0);
        step();
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        total++; if ({rsp_valid, rsp_error} !== 2'b10) begin bad++; $display("FAIL zmask_rsp got=%b%b exp=10", rsp_valid, rsp_error); end
        step();
        total++; if (rsp_data !== 32'hC0DE0FFF) begin bad++; $display("FAIL zmask_data got=%h exp=c0de0fff", rsp_data); end
        step();
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int got = 0;
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 14'h3000, 4'hF, 32'd0);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_acc0 got=%b exp=1", cmd_ready); end
        step(); issued++;
        drive(1'b1, 1'b0, 14'h3004, 4'hF, 32'd0);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_acc1 got=%b exp=1", cmd_ready); end
        step(); issued++;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 14'h3008, 4'hF, 32'd0);
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_stall%0d got=%b exp=0", c, cmd_ready); end
            step();
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            drive(issued < 4, 1'b0, 14'(14'h3000 + 4 * issued), 4'hF, 32'd0);
            if (rsp_valid) begin
                total++; if (rsp_data !== 32'hC0DE0C00 + got) begin bad++; $display("FAIL bp_rsp%0d got=%h exp=%h", got, rsp_data, 32'hC0DE0C00 + got); end
                got++;
            end
            if (cmd_valid && cmd_ready) issued++;
            step();
        end
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        total++; if (got !== 4 || issued !== 4) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=4/4", got, issued); end
    endtask

    task automatic test_stream();
        int issued = 0;
        int got = 0;
        int stalls = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && got < 64; c++) begin
            drive(issued < 64, 1'b0, 14'(14'h2400 + 4 * issued), 4'hF, 32'd0);
            if (cmd_valid && !cmd_ready) stalls++;
            if (rsp_valid) begin
                total++; if (rsp_data !== 32'hC0DE0900 + got) begin bad++; $display("FAIL stream_rsp%0d got=%h exp=%h", got, rsp_data, 32'hC0DE0900 + got); end
                got++;
            end
            if (cmd_valid && cmd_ready) issued++;
            step();
        end
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        total++; if (stalls !== 0) begin bad++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
        total++; if (got !== 64) begin bad++; $display("FAIL stream_count got=%0d exp=64", got); end
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 14'h0800, 4'hF, 32'd0);
        step();
        drive(1'b1, 1'b0, 14'h0804, 4'hF, 32'd0);
        step();
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        reset = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0", cmd_ready); end
        step();
        reset = 1'b0;
        #1;
        total++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b00, 32'd0}) begin bad++; $display("FAIL mid_reset_rsp got=%b%b%h exp=00 00000000", rsp_valid, rsp_error, rsp_data); end
        step(); step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_stale got=%b exp=0", rsp_valid); end
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 14'h1000, 4'hF, 32'd0);
        step();
        drive(1'b0, 1'b0, 14'h0000, 4'h0, 32'd0);
        step();
        total++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL mid_reset_read got=%b %h exp=1 deadbeef", rsp_valid, rsp_data); end
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_extra got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[12'h800] = 32'hAABBCCDD;
        rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_masked_write();
        test_rom_protect();
        test_zero_mask();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
